// File: rtl/sd_spi_test_seq.sv
// sd_spi_test_seq: multi-sector write/read-back self-test sequencer for sd_spi_controller.
// Writes SEC_NUM sectors of a generated pattern starting at SEC_BASE, reads them back,
// checks every word and the per-sector word count, and flags busy-handshake timeouts.
// Optional feature macro SD_TEST_LOOP_EN: DONE pauses 2^20 cycles and then starts a new pass;
// when undefined, DONE is terminal until reset.
module sd_spi_test_seq #(
  parameter logic [31:0] SEC_BASE      = 32'd2000,
  parameter int          SEC_NUM       = 4,
  parameter int          WORDS_PER_SEC = 256,
  parameter int          PATTERN       = 0,
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter logic [23:0] TIMEOUT       = 24'd2_000_000
) (
  input  logic        clk_sd,
  input  logic        reset_n,
  input  logic        sd_init_done,
  input  logic        wr_busy,
  input  logic        wr_req,
  output logic        wr_start_en,
  output logic [31:0] wr_sec_addr,
  output logic [15:0] wr_data,
  input  logic        rd_busy,
  input  logic        rd_en,
  input  logic [15:0] rd_data,
  output logic        rd_start_en,
  output logic [31:0] rd_sec_addr,
  output logic        error_flag,
  output logic        test_done,
  output logic [15:0] err_cnt,
  output logic [15:0] pass_cnt
);

  typedef enum logic [2:0] {
    IDLE, WR_START, WR_WAIT, WR_BUSY, RD_START, RD_WAIT, RD_BUSY, DONE
  } state_t;

  localparam logic [15:0] LAST_SEC = 16'(SEC_NUM - 1);
  localparam logic [15:0] WPS      = 16'(WORDS_PER_SEC);

  state_t      state, state_nxt;
  logic [15:0] sec_idx, sec_nxt, word_idx, lfsr, lin_word, cur_word;
  logic [23:0] tmo_cnt;
  logic        abort, last_sec, tmo_hit, wr_take, rd_take;
  logic        rd_mismatch, rd_cnt_bad, wr_phase;
`ifdef SD_TEST_LOOP_EN
  logic [19:0] done_cnt;
`endif

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right; taps land on bits 0,2,3,5
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // Losing sd_init_done mid-pass abandons the pass; a finished pass is left alone
  assign abort    = !sd_init_done && (state != IDLE) && (state != DONE);
  assign last_sec = (sec_idx == LAST_SEC);
  assign tmo_hit  = (tmo_cnt == TIMEOUT - 24'd1);
  assign wr_take  = (state == WR_BUSY) && wr_req;
  assign rd_take  = (state == RD_BUSY) && rd_en;
  assign lin_word = 16'(32'(sec_idx) * 32'(WORDS_PER_SEC) + 32'(word_idx));
  assign cur_word = (PATTERN == 0) ? lin_word : lfsr;
  assign rd_mismatch = rd_take && (rd_data != cur_word);
  // A word arriving on the same cycle busy falls is counted before the length check
  assign rd_cnt_bad  = (state == RD_BUSY) && !rd_busy && !abort &&
                       ((word_idx + 16'(rd_take)) != WPS);

  // State register
  always_ff @(posedge clk_sd or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (sd_init_done && !wr_busy) state_nxt = WR_START;
      WR_START: state_nxt = WR_WAIT;
      WR_WAIT:  if (wr_busy) state_nxt = WR_BUSY;
                else if (tmo_hit) state_nxt = DONE;
      WR_BUSY:  if (!wr_busy) state_nxt = last_sec ? RD_START : WR_START;
      RD_START: state_nxt = RD_WAIT;
      RD_WAIT:  if (rd_busy) state_nxt = RD_BUSY;
                else if (tmo_hit) state_nxt = DONE;
      RD_BUSY:  if (!rd_busy) state_nxt = last_sec ? DONE : RD_START;
`ifdef SD_TEST_LOOP_EN
      DONE:     if (done_cnt == 20'hFFFFF) state_nxt = IDLE;
`else
      DONE:     state_nxt = DONE;
`endif
      default:  state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Moore outputs; wr_data shows the pattern only while a write is in flight
  always_comb begin
    wr_start_en = 1'b0;
    rd_start_en = 1'b0;
    test_done   = 1'b0;
    wr_phase    = 1'b0;
    case (state)
      WR_START: begin
        wr_start_en = 1'b1;
        wr_phase    = 1'b1;
      end
      WR_WAIT, WR_BUSY: wr_phase = 1'b1;
      RD_START: rd_start_en = 1'b1;
      DONE:     test_done = 1'b1;
      default:  ;
    endcase
    wr_data = wr_phase ? cur_word : 16'd0;
  end

  // Sector index for the next cycle; it restarts at 0 for the read phase
  always_comb begin
    sec_nxt = sec_idx;
    if (abort || state == IDLE || state == DONE)
      sec_nxt = '0;
    else if (state == WR_BUSY && !wr_busy)
      sec_nxt = last_sec ? 16'd0 : sec_idx + 16'd1;
    else if (state == RD_BUSY && !rd_busy && !last_sec)
      sec_nxt = sec_idx + 16'd1;
  end

  // Pattern generator, sector addressing, timeout counter and result counters
  always_ff @(posedge clk_sd or negedge reset_n) begin
    if (!reset_n) begin
      sec_idx     <= '0;
      word_idx    <= '0;
      lfsr        <= SEED;
      tmo_cnt     <= '0;
      wr_sec_addr <= SEC_BASE;
      rd_sec_addr <= SEC_BASE;
      error_flag  <= 1'b0;
      err_cnt     <= '0;
      pass_cnt    <= '0;
    end else begin
      sec_idx <= sec_nxt;
      if (state == IDLE || state_nxt == WR_START || state_nxt == RD_START)
        word_idx <= '0;
      else if (wr_take || rd_take)
        word_idx <= word_idx + 16'd1;
      // Reseed while idle (covers the start of the write phase) and when reads begin
      if (state == IDLE || (state == WR_BUSY && state_nxt == RD_START))
        lfsr <= SEED;
      else if (wr_take || rd_take)
        lfsr <= lfsr_step(lfsr);
      // Counting starts in the pulse cycle, so busy must rise within TIMEOUT cycles of it
      if (state inside {WR_START, WR_WAIT, RD_START, RD_WAIT})
        tmo_cnt <= tmo_cnt + 24'd1;
      else
        tmo_cnt <= '0;
      if (state_nxt == WR_START) wr_sec_addr <= SEC_BASE + 32'(sec_nxt);
      if (state_nxt == RD_START) rd_sec_addr <= SEC_BASE + 32'(sec_nxt);
      if (rd_mismatch || rd_cnt_bad ||
          ((state == WR_WAIT || state == RD_WAIT) && state_nxt == DONE))
        error_flag <= 1'b1;
      if (rd_mismatch && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
      if (state_nxt == DONE && state != DONE)
        pass_cnt <= pass_cnt + 16'd1;
    end
  end

`ifdef SD_TEST_LOOP_EN
  // Dwell counter for the pause between passes
  always_ff @(posedge clk_sd or negedge reset_n) begin
    if (!reset_n)           done_cnt <= '0;
    else if (state == DONE) done_cnt <= done_cnt + 20'd1;
    else                    done_cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_sd_spi_test_seq.sv
// Testbench for sd_spi_test_seq: two instances (incrementing and LFSR pattern) share one
// randomized ideal-controller model; expected words come from a reference sequence table.
module tb_sd_spi_test_seq;

  localparam int          WPS  = 256;
  localparam int          NSEC = 2;
  localparam logic [31:0] BASE = 32'd2000;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk_sd = 1'b0;
  always #5 clk_sd = ~clk_sd;

  logic        reset_n, sd_init_done, wr_busy, wr_req, rd_busy, rd_en;
  logic [15:0] rd_data0, rd_data1;
  logic        wr_start_en [2];
  logic        rd_start_en [2];
  logic        error_flag  [2];
  logic        test_done   [2];
  logic [31:0] wr_sec_addr [2];
  logic [31:0] rd_sec_addr [2];
  logic [15:0] wr_data     [2];
  logic [15:0] err_cnt     [2];
  logic [15:0] pass_cnt    [2];

  int vectors = 0;
  int miscompares = 0;
  int kph = 0;
  logic [15:0] lfsr_seq [0:1023];

  sd_spi_test_seq #(.SEC_BASE(BASE), .SEC_NUM(NSEC), .WORDS_PER_SEC(WPS), .PATTERN(0),
                    .SEED(SEED), .TIMEOUT(24'd100)) dut0 (
    .clk_sd(clk_sd), .reset_n(reset_n), .sd_init_done(sd_init_done),
    .wr_busy(wr_busy), .wr_req(wr_req), .wr_start_en(wr_start_en[0]),
    .wr_sec_addr(wr_sec_addr[0]), .wr_data(wr_data[0]),
    .rd_busy(rd_busy), .rd_en(rd_en), .rd_data(rd_data0), .rd_start_en(rd_start_en[0]),
    .rd_sec_addr(rd_sec_addr[0]), .error_flag(error_flag[0]), .test_done(test_done[0]),
    .err_cnt(err_cnt[0]), .pass_cnt(pass_cnt[0]));

  sd_spi_test_seq #(.SEC_BASE(BASE), .SEC_NUM(NSEC), .WORDS_PER_SEC(WPS), .PATTERN(1),
                    .SEED(SEED), .TIMEOUT(24'd100)) dut1 (
    .clk_sd(clk_sd), .reset_n(reset_n), .sd_init_done(sd_init_done),
    .wr_busy(wr_busy), .wr_req(wr_req), .wr_start_en(wr_start_en[1]),
    .wr_sec_addr(wr_sec_addr[1]), .wr_data(wr_data[1]),
    .rd_busy(rd_busy), .rd_en(rd_en), .rd_data(rd_data1), .rd_start_en(rd_start_en[1]),
    .rd_sec_addr(rd_sec_addr[1]), .error_flag(error_flag[1]), .test_done(test_done[1]),
    .err_cnt(err_cnt[1]), .pass_cnt(pass_cnt[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sd);
  endtask

  // Expected data: pattern 0 is the linear word number; pattern 1 is the k-th LFSR state
  function automatic logic [15:0] exp_word(input int p, input int sec, input int idx, input int k);
    logic [31:0] lin;
    lin = 32'(sec * WPS + idx);
    if (p == 0) return lin[15:0];
    return lfsr_seq[k];
  endfunction

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_wr_start"}, 32'(wr_start_en[d]), 0);
      chk({tag, "_rd_start"}, 32'(rd_start_en[d]), 0);
      chk({tag, "_done"},     32'(test_done[d]), 0);
      chk({tag, "_err_flag"}, 32'(error_flag[d]), 0);
      chk({tag, "_err_cnt"},  32'(err_cnt[d]), 0);
      chk({tag, "_pass_cnt"}, 32'(pass_cnt[d]), 0);
      chk({tag, "_wr_data"},  32'(wr_data[d]), 0);
      chk({tag, "_wr_addr"},  wr_sec_addr[d], BASE);
      chk({tag, "_rd_addr"},  rd_sec_addr[d], BASE);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_sd);
    reset_n = 1'b0; wr_busy = 1'b0; wr_req = 1'b0; rd_busy = 1'b0; rd_en = 1'b0;
    #1;
    check_reset_state("reset");
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_start(input bit rd, input int sec);
    int n;
    n = 0;
    while (((rd ? rd_start_en[0] : wr_start_en[0]) !== 1'b1) && n < 50) begin
      tick();
      n++;
    end
    chk(rd ? "rd_start_seen" : "wr_start_seen", 32'(n < 50), 1);
    for (int d = 0; d < 2; d++) begin
      chk(rd ? "rd_start_both" : "wr_start_both", 32'(rd ? rd_start_en[d] : wr_start_en[d]), 1);
      chk(rd ? "rd_sec_addr" : "wr_sec_addr", rd ? rd_sec_addr[d] : wr_sec_addr[d],
          BASE + 32'(sec));
    end
    tick();
    chk(rd ? "rd_start_1cyc" : "wr_start_1cyc", 32'(rd ? rd_start_en[0] : wr_start_en[0]), 0);
  endtask

  task automatic wr_sector(input int sec);
    wait_start(0, sec);
    repeat ($urandom_range(0, 5)) tick();
    wr_busy = 1'b1;
    tick();
    for (int i = 0; i < WPS; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      chk("wr_data_p0", 32'(wr_data[0]), 32'(exp_word(0, sec, i, kph)));
      chk("wr_data_p1", 32'(wr_data[1]), 32'(exp_word(1, sec, i, kph)));
      wr_req = 1'b1;
      tick();
      wr_req = 1'b0;
      kph++;
    end
    wr_busy = 1'b0;
    tick();
  endtask

  task automatic rd_sector(input int sec, input int nw, input int flip_idx, input bit fall_last);
    wait_start(1, sec);
    repeat ($urandom_range(0, 5)) tick();
    rd_busy = 1'b1;
    tick();
    for (int i = 0; i < nw; i++) begin
      repeat ($urandom_range(0, 2)) begin
        rd_data0 = 16'($urandom);
        rd_data1 = 16'($urandom);
        tick();
      end
      rd_en    = 1'b1;
      rd_data0 = exp_word(0, sec, i, kph) ^ 16'(i == flip_idx);
      rd_data1 = exp_word(1, sec, i, kph) ^ 16'(i == flip_idx);
      if (fall_last && i == nw - 1) rd_busy = 1'b0;
      tick();
      rd_en    = 1'b0;
      rd_data0 = 16'($urandom);
      rd_data1 = 16'($urandom);
      kph++;
    end
    if (!fall_last) begin
      rd_busy = 1'b0;
      tick();
    end
  endtask

  task automatic run_pass(input int flip_sec, input int flip_idx, input int short_sec,
                          input bit fall_last);
    kph = 0;
    for (int s = 0; s < NSEC; s++) wr_sector(s);
    kph = 0;
    for (int s = 0; s < NSEC; s++)
      rd_sector(s, (s == short_sec) ? WPS - 1 : WPS, (s == flip_sec) ? flip_idx : -1,
                fall_last && (s == NSEC - 1));
  endtask

  task automatic check_end(input string tag, input bit ef, input int ec, input int pc);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_test_done"},  32'(test_done[d]), 1);
      chk({tag, "_error_flag"}, 32'(error_flag[d]), 32'(ef));
      chk({tag, "_err_cnt"},    32'(err_cnt[d]), 32'(ec));
      chk({tag, "_pass_cnt"},   32'(pass_cnt[d]), 32'(pc));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] s;
    int n;
    bit seen;
    reset_n = 1'b0; sd_init_done = 1'b0; wr_busy = 1'b0; wr_req = 1'b0;
    rd_busy = 1'b0; rd_en = 1'b0; rd_data0 = '0; rd_data1 = '0;
    // Reference LFSR sequence: taps x^16, x^14, x^13, x^11 sit at bits 0, 2, 3, 5
    s = SEED;
    for (int i = 0; i < 1024; i++) begin
      lfsr_seq[i] = s;
      s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    end

    repeat (3) tick();
    check_reset_state("por");
    reset_n = 1'b1;
    repeat (5) tick();
    chk("no_start_wo_init", 32'(wr_start_en[0]), 0);

    // Clean pass, last read word coincides with busy falling
    sd_init_done = 1'b1;
    run_pass(-1, -1, -1, 1'b1);
    check_end("clean", 1'b0, 0, 1);
    repeat (20) tick();
    chk("done_terminal", 32'(test_done[0]), 1);
    chk("done_no_restart", 32'(wr_start_en[0]), 0);
    chk("done_pass_hold", 32'(pass_cnt[1]), 1);

    // Bit 0 of word 5 in sector 1 corrupted on read-back
    do_reset();
    run_pass(1, 5, -1, 1'b0);
    check_end("flip", 1'b1, 1, 1);

    // wr_busy never rises: error exactly 100 cycles after the pulse, no read started
    do_reset();
    wait_start(0, 0);
    n = 1;
    while (error_flag[0] !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 32'(n), 100);
    chk("timeout_flag_p1", 32'(error_flag[1]), 1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rd_start_en[0] === 1'b1 || rd_start_en[1] === 1'b1) seen = 1'b1;
      tick();
    end
    chk("timeout_no_rd_start", 32'(seen), 0);
    chk("timeout_done", 32'(test_done[0]), 1);
    chk("timeout_pass_cnt", 32'(pass_cnt[0]), 1);

    // Sector 0 read-back short by one word
    do_reset();
    run_pass(-1, -1, 0, 1'b0);
    check_end("short", 1'b1, 0, 1);

    // sd_init_done drops during the sector 1 write, then the pass restarts from SEC_BASE
    do_reset();
    kph = 0;
    wr_sector(0);
    wait_start(0, 1);
    wr_busy = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("abort_pre_data", 32'(wr_data[1]), 32'(exp_word(1, 1, i, kph)));
      wr_req = 1'b1;
      tick();
      wr_req = 1'b0;
      kph++;
    end
    sd_init_done = 1'b0;
    tick();
    chk("abort_test_done", 32'(test_done[0]), 0);
    wr_busy = 1'b0;
    repeat (3) tick();
    chk("abort_no_start", 32'(wr_start_en[1]), 0);
    sd_init_done = 1'b1;
    run_pass(-1, -1, -1, 1'b0);
    check_end("restart", 1'b0, 0, 1);

    // Reset in the middle of a read after a mismatch has been recorded
    do_reset();
    run_pass(-1, -1, -1, 1'b0);
    do_reset();
    kph = 0;
    for (int sct = 0; sct < NSEC; sct++) wr_sector(sct);
    kph = 0;
    wait_start(1, 0);
    rd_busy = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      rd_en    = 1'b1;
      rd_data0 = exp_word(0, 0, i, kph) ^ 16'(i == 3);
      rd_data1 = exp_word(1, 0, i, kph) ^ 16'(i == 3);
      tick();
      rd_en = 1'b0;
      kph++;
    end
    chk("midread_err_flag", 32'(error_flag[1]), 1);
    chk("midread_err_cnt", 32'(err_cnt[0]), 1);
    reset_n = 1'b0;
    #1;
    check_reset_state("midread");
    rd_busy = 1'b0;
    tick();
    reset_n = 1'b1;
    wait_start(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
